// File: rtl/fpu_ex_seq_if.sv
// Handshake bundle between the FPU execute sequencer and the SIMD FP unit.
// Signals: unitStart/unitOp (to unit), unitValid/unitData (per-lane results back).
interface fpu_ex_seq_if #(
    parameter int LANES  = 1,
    parameter int LANE_W = 64
) ();
    logic                    unitStart;
    logic [1:0]              unitOp;
    logic [LANES-1:0]        unitValid;
    logic [LANES*LANE_W-1:0] unitData;

    modport master (
        output unitStart,
        output unitOp,
        input  unitValid,
        input  unitData
    );

    modport slave (
        input  unitStart,
        input  unitOp,
        output unitValid,
        output unitData
    );
endinterface

// File: rtl/fpu_ex_seq.sv
// Sequences predicated FPU3 add/sub/mul/move ops onto a LANES-wide SIMD FP unit.
// Ports: clock/reset, EX command inputs, FP unit bus (unit), result/status outputs.
module fpu_ex_seq #(
    parameter int          LANES   = 1,
    parameter int          LANE_W  = 64,
    parameter int          REGID_W = 6,
    parameter int          CNT_W   = 4,
    parameter int          ADD_LAT = 5,
    parameter int          MUL_LAT = 5,
    parameter logic [5:0]  OP_FPU3 = 6'h1A
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [8:0]              opCmd,
    input  logic [8:0]              regIdIxt,
    input  logic [REGID_W-1:0]      regIdRn,
    input  logic [LANES*LANE_W-1:0] regValRs,
    input  logic                    regInSrT,
    input  logic                    braFlush,
    input  logic                    exHold,
    fpu_ex_seq_if.master            unit,
    output logic [LANES*LANE_W-1:0] regOutVal,
    output logic [REGID_W-1:0]      regOutId,
    output logic [1:0]              regOutOK,
    output logic                    regOutHold,
    output logic                    timeoutErr
);
    localparam int VW = LANES * LANE_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [7:0]          l_cmd;
    logic [3:0]          l_sub;
    logic [REGID_W-1:0]  l_rn;
    logic [VW-1:0]       l_rs;
    logic                l_flush;

    logic [LANES-1:0]    mask;
    logic [CNT_W-1:0]    cnt;
    logic [VW-1:0]       data;
    logic                fault;

    logic                en;
    logic                fpu3;
    logic                op_arith;
    logic                op_move;
    logic                start;
    logic                mask_all;
    logic                at_lat;
    logic                latch_en;
    logic [CNT_W-1:0]    lat;

    logic                unused_bits;
    assign unused_bits = ^{opCmd[8], regIdIxt[8:4]};

    // Decode from latched command; predicate uses live SR.T.
    always_comb begin
        en = 1'b0;
        unique case (l_cmd[7:6])
            2'b00: en = 1'b1;
            2'b01: en = 1'b0;
            2'b10: en = regInSrT;
            2'b11: en = !regInSrT;
            default: en = 1'b0;
        endcase
        if (l_flush)
            en = 1'b0;
        fpu3     = (l_cmd[5:0] == OP_FPU3);
        op_arith = en && fpu3 && (l_sub <= 4'd2);
        op_move  = en && fpu3 && (l_sub == 4'd4);
        start    = (state == S_IDLE) && op_arith;
        mask_all = &(mask | unit.unitValid);
        lat      = (l_sub == 4'd2) ? CNT_W'(MUL_LAT) : CNT_W'(ADD_LAT);
        at_lat   = (cnt == lat);
        // The latch stays frozen from the start pulse until DONE retires,
        // so the in-flight op keeps its sub-op and destination.
        latch_en = !exHold &&
                   (((state == S_IDLE) && !start) || (state == S_DONE));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            l_cmd   <= '0;
            l_sub   <= '0;
            l_rn    <= '0;
            l_rs    <= '0;
            l_flush <= 1'b0;
        end else if (latch_en) begin
            l_cmd   <= opCmd[7:0];
            l_sub   <= regIdIxt[3:0];
            l_rn    <= regIdRn;
            l_rs    <= regValRs;
            l_flush <= braFlush;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_WAIT;
            S_WAIT: if (mask_all || at_lat) state_nxt = S_DONE;
            S_DONE: if (!exHold) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mask       <= '0;
            cnt        <= '0;
            data       <= '0;
            fault      <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= CNT_W'(1);
                        mask  <= '0;
                        data  <= '0;
                        fault <= 1'b0;
                    end
                end
                S_WAIT: begin
                    mask <= mask | unit.unitValid;
                    for (int i = 0; i < LANES; i++) begin
                        if (unit.unitValid[i])
                            data[i*LANE_W +: LANE_W] <=
                                unit.unitData[i*LANE_W +: LANE_W];
                    end
                    if (!mask_all) begin
                        if (at_lat) begin
                            fault      <= 1'b1;
                            timeoutErr <= 1'b1;
                        end else if (cnt != '1) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        unit.unitStart = 1'b0;
        unit.unitOp    = 2'd0;
        regOutVal      = '0;
        regOutId       = '1;
        regOutOK       = 2'b00;
        regOutHold     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    unit.unitStart = 1'b1;
                    unit.unitOp    = l_sub[1:0] + 2'd1;
                end else if (op_move) begin
                    regOutVal = l_rs;
                    regOutId  = l_rn;
                    regOutOK  = 2'b01;
                end else if (en && fpu3) begin
                    regOutId  = l_rn;
                    regOutOK  = 2'b01;
                end
            end
            S_WAIT: begin
                regOutHold = 1'b1;
                regOutOK   = 2'b10;
                regOutId   = l_rn;
            end
            S_DONE: begin
                regOutVal = data;
                regOutId  = l_rn;
                regOutOK  = fault ? 2'b11 : 2'b01;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fpu_ex_seq.sv
// Directed self-checking bench for fpu_ex_seq with two 64-bit lanes.
// Covers reset, add, move, predication, flush, DONE stall, timeout, mid-op reset.
module tb_fpu_ex_seq;
    logic         clock = 1'b0;
    logic         reset;
    logic [8:0]   opCmd;
    logic [8:0]   regIdIxt;
    logic [5:0]   regIdRn;
    logic [127:0] regValRs;
    logic         regInSrT;
    logic         braFlush;
    logic         exHold;
    logic [127:0] regOutVal;
    logic [5:0]   regOutId;
    logic [1:0]   regOutOK;
    logic         regOutHold;
    logic         timeoutErr;

    int n_tests = 0;
    int n_fail  = 0;
    int hc;

    fpu_ex_seq_if #(.LANES(2), .LANE_W(64)) unit_bus ();

    fpu_ex_seq #(.LANES(2), .LANE_W(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .opCmd      (opCmd),
        .regIdIxt   (regIdIxt),
        .regIdRn    (regIdRn),
        .regValRs   (regValRs),
        .regInSrT   (regInSrT),
        .braFlush   (braFlush),
        .exHold     (exHold),
        .unit       (unit_bus),
        .regOutVal  (regOutVal),
        .regOutId   (regOutId),
        .regOutOK   (regOutOK),
        .regOutHold (regOutHold),
        .timeoutErr (timeoutErr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic nop();
        opCmd    = 9'h000;
        regIdIxt = 9'h000;
        braFlush = 1'b0;
    endtask

    initial begin
        reset              = 1'b0;
        opCmd              = 9'($urandom);
        regIdIxt           = 9'($urandom);
        regIdRn            = 6'($urandom);
        regValRs           = {$urandom, $urandom, $urandom, $urandom};
        regInSrT           = 1'($urandom);
        braFlush           = 1'($urandom);
        exHold             = 1'($urandom);
        unit_bus.unitValid = 2'($urandom);
        unit_bus.unitData  = {$urandom, $urandom, $urandom, $urandom};
        tick();
        tick();
        chk("rst_val",   regOutVal, 128'h0);
        chk("rst_id",    regOutId, 6'h3F);
        chk("rst_ok",    regOutOK, 2'b00);
        chk("rst_hold",  regOutHold, 1'b0);
        chk("rst_start", unit_bus.unitStart, 1'b0);
        chk("rst_tmo",   timeoutErr, 1'b0);

        reset = 1'b1;
        nop();
        regIdRn = 6'd0;
        regValRs = '0;
        regInSrT = 1'b0;
        exHold = 1'b0;
        unit_bus.unitValid = 2'b00;
        unit_bus.unitData = '0;
        tick();

        // add, lane0 at WAIT cycle 2, lane1 at cycle 4
        opCmd = 9'h01A;
        regIdIxt = 9'd0;
        regIdRn = 6'd5;
        tick();
        chk("add_start", unit_bus.unitStart, 1'b1);
        chk("add_op", unit_bus.unitOp, 2'd1);
        hc = 0;
        tick();
        hc += int'(regOutHold);
        chk("add_wait_ok", regOutOK, 2'b10);
        chk("add_wait_start", unit_bus.unitStart, 1'b0);
        tick();
        hc += int'(regOutHold);
        unit_bus.unitValid = 2'b01;
        unit_bus.unitData = {64'hDEAD_BEEF_0000_0001, 64'h4000000000000000};
        tick();
        hc += int'(regOutHold);
        unit_bus.unitValid = 2'b00;
        tick();
        hc += int'(regOutHold);
        unit_bus.unitValid = 2'b10;
        unit_bus.unitData = {64'h3FF0000000000000, 64'h1111_2222_3333_4444};
        tick();
        unit_bus.unitValid = 2'b00;
        chk("add_hold_cycles", hc, 4);
        chk("add_done_hold", regOutHold, 1'b0);
        chk("add_done_val", regOutVal,
            {64'h3FF0000000000000, 64'h4000000000000000});
        chk("add_done_id", regOutId, 6'd5);
        chk("add_done_ok", regOutOK, 2'b01);
        nop();
        tick();
        chk("add_idle_ok", regOutOK, 2'b00);
        chk("add_idle_id", regOutId, 6'h3F);

        // move
        opCmd = 9'h01A;
        regIdIxt = 9'd4;
        regIdRn = 6'd9;
        regValRs = {64'hCAFE_0000_0000_0002, 64'h0123_4567_89AB_CDEF};
        tick();
        chk("mov_val", regOutVal,
            {64'hCAFE_0000_0000_0002, 64'h0123_4567_89AB_CDEF});
        chk("mov_ok", regOutOK, 2'b01);
        chk("mov_hold", regOutHold, 1'b0);
        chk("mov_start", unit_bus.unitStart, 1'b0);
        nop();
        tick();

        // CF with T=1 disabled
        opCmd = 9'h0DA;
        regInSrT = 1'b1;
        tick();
        chk("cf_start", unit_bus.unitStart, 1'b0);
        chk("cf_ok", regOutOK, 2'b00);
        nop();
        tick();

        // CT sub: T=0 disabled, then live T=1 fires
        regInSrT = 1'b0;
        opCmd = 9'h09A;
        regIdIxt = 9'd1;
        regIdRn = 6'd2;
        tick();
        chk("ct0_start", unit_bus.unitStart, 1'b0);
        chk("ct0_ok", regOutOK, 2'b00);
        regInSrT = 1'b1;
        #1;
        chk("ct1_start", unit_bus.unitStart, 1'b1);
        chk("ct1_op", unit_bus.unitOp, 2'd2);
        tick();
        nop();
        unit_bus.unitValid = 2'b11;
        unit_bus.unitData = {64'h5, 64'h6};
        tick();
        unit_bus.unitValid = 2'b00;
        chk("ct_done_ok", regOutOK, 2'b01);
        chk("ct_done_val", regOutVal, {64'h5, 64'h6});
        regInSrT = 1'b0;
        tick();

        // latched flush suppresses
        opCmd = 9'h01A;
        regIdIxt = 9'd0;
        braFlush = 1'b1;
        tick();
        chk("fl_start", unit_bus.unitStart, 1'b0);
        chk("fl_ok", regOutOK, 2'b00);
        nop();
        tick();

        // stall in DONE
        opCmd = 9'h01A;
        regIdIxt = 9'd0;
        regIdRn = 6'd3;
        tick();
        chk("st_start", unit_bus.unitStart, 1'b1);
        tick();
        unit_bus.unitValid = 2'b11;
        unit_bus.unitData = {64'hBBBB, 64'hAAAA};
        tick();
        exHold = 1'b1;
        opCmd = 9'h01A;
        regIdIxt = 9'd4;
        regIdRn = 6'd12;
        regValRs = {64'h7777, 64'h8888};
        unit_bus.unitData = {64'h9999, 64'h9999};
        chk("st_done_val", regOutVal, {64'hBBBB, 64'hAAAA});
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_hold_val", regOutVal, {64'hBBBB, 64'hAAAA});
            chk("st_hold_id", regOutId, 6'd3);
            chk("st_hold_ok", regOutOK, 2'b01);
        end
        exHold = 1'b0;
        unit_bus.unitValid = 2'b00;
        tick();
        chk("st_new_val", regOutVal, {64'h7777, 64'h8888});
        chk("st_new_ok", regOutOK, 2'b01);
        nop();
        tick();

        // mul timeout, only lane0 strobes
        opCmd = 9'h01A;
        regIdIxt = 9'd2;
        regIdRn = 6'd7;
        tick();
        chk("to_start", unit_bus.unitStart, 1'b1);
        chk("to_op", unit_bus.unitOp, 2'd3);
        hc = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            hc += int'(regOutHold);
            unit_bus.unitValid = (i == 0) ? 2'b01 : 2'b00;
            unit_bus.unitData = {64'h5555, 64'h1234};
        end
        tick();
        unit_bus.unitValid = 2'b00;
        chk("to_hold_cycles", hc, 5);
        chk("to_ok", regOutOK, 2'b11);
        chk("to_val", regOutVal, {64'h0, 64'h1234});
        chk("to_id", regOutId, 6'd7);
        chk("to_err", timeoutErr, 1'b1);
        nop();
        tick();
        chk("to_err_sticky", timeoutErr, 1'b1);
        chk("to_idle_ok", regOutOK, 2'b00);

        // reset at WAIT counter 2, then late strobe
        opCmd = 9'h01A;
        regIdIxt = 9'd0;
        regIdRn = 6'd4;
        tick();
        tick();
        tick();
        chk("mr_wait_hold", regOutHold, 1'b1);
        nop();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        unit_bus.unitValid = 2'b11;
        unit_bus.unitData = {64'hF00D, 64'hBEEF};
        tick();
        unit_bus.unitValid = 2'b00;
        chk("mr_ok", regOutOK, 2'b00);
        chk("mr_hold", regOutHold, 1'b0);
        chk("mr_val", regOutVal, 128'h0);
        chk("mr_id", regOutId, 6'h3F);
        chk("mr_tmo", timeoutErr, 1'b0);
        tick();
        chk("mr_val2", regOutVal, 128'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
